// File: rtl/iir_lowpass_single_pole_mc_pkg.sv
// rtl/iir_lowpass_single_pole_mc_pkg.sv - shared FSM encoding and width helpers for the multi-channel IIR low-pass
package iir_lowpass_single_pole_mc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } fsm_state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2_f(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

  // Channel tag width; a single channel still needs a one-bit tag.
  function automatic int ch_bits_f(input int channels);
    return (clog2_f(channels) < 1) ? 1 : clog2_f(channels);
  endfunction

  // Accumulator width: enough headroom for a full-scale DC input at any pole shift.
  function automatic int acc_width_f(input int width, input int gain);
    return width + gain;
  endfunction

endpackage

// File: rtl/iir_lowpass_single_pole_mc_if.sv
// rtl/iir_lowpass_single_pole_mc_if.sv - sample in/out bus; out_hp present when IIR_LP_HIGHPASS_OUT_EN is defined
interface iir_lowpass_single_pole_mc_if
  import iir_lowpass_single_pole_mc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) ();

  localparam int CH_BITS = ch_bits_f(CHANNELS);

  logic                      in_valid;
  logic                      in_ready;
  logic [CH_BITS-1:0]        in_ch;
  logic signed [WIDTH-1:0]   in;
  logic                      out_valid;
  logic [CH_BITS-1:0]        out_ch;
  logic signed [WIDTH-1:0]   out;
`ifdef IIR_LP_HIGHPASS_OUT_EN
  logic signed [WIDTH-1:0]   out_hp;

  modport master (
    output in_valid, in_ch, in,
    input  in_ready, out_valid, out_ch, out, out_hp
  );

  modport slave (
    input  in_valid, in_ch, in,
    output in_ready, out_valid, out_ch, out, out_hp
  );
`else
  modport master (
    output in_valid, in_ch, in,
    input  in_ready, out_valid, out_ch, out
  );

  modport slave (
    input  in_valid, in_ch, in,
    output in_ready, out_valid, out_ch, out
  );
`endif

endinterface

// File: rtl/iir_lowpass_single_pole_mc_state_bank.sv
// rtl/iir_lowpass_single_pole_mc_state_bank.sv - per-channel accumulator array with async read, sync write and indexed clear
module iir_lowpass_single_pole_mc_state_bank #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 24,
  parameter int CH_BITS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_BITS-1:0]      rd_idx,
  output logic signed [ACC_W-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [CH_BITS-1:0]      wr_idx,
  input  logic signed [ACC_W-1:0] wr_data,
  input  logic                    clr_en,
  input  logic [CH_BITS-1:0]      clr_idx
);

  logic signed [ACC_W-1:0] mem_q [CHANNELS];
  logic signed [ACC_W-1:0] mem_d [CHANNELS];

  // Read mux; an index with no matching channel returns zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_idx == CH_BITS'(i)) rd_data = mem_q[i];
    end
  end

  // Next-state per entry: clear wins over write (they never coincide in practice).
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      mem_d[i] = mem_q[i];
      if (clr_en && (clr_idx == CH_BITS'(i))) begin
        mem_d[i] = '0;
      end else if (wr_en && (wr_idx == CH_BITS'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  // Accumulator storage with synchronous clear on reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst) mem_q[i] <= '0;
      else     mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/iir_lowpass_single_pole_mc.sv
// rtl/iir_lowpass_single_pole_mc.sv - time-multiplexed single-pole IIR low-pass; IIR_LP_HIGHPASS_OUT_EN adds out_hp
module iir_lowpass_single_pole_mc
  import iir_lowpass_single_pole_mc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int GAIN     = 8,
  parameter int CHANNELS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          flush,
  output logic                          busy,
  iir_lowpass_single_pole_mc_if.slave   bus
);

  localparam int CH_BITS = ch_bits_f(CHANNELS);
  localparam int ACC_W   = acc_width_f(WIDTH, GAIN);
  localparam logic [CH_BITS-1:0] LAST_IDX = CH_BITS'(CHANNELS - 1);
  localparam logic [CH_BITS:0]   CH_LIMIT = (CH_BITS + 1)'(CHANNELS);

  fsm_state_e              state_q, state_d;
  logic [CH_BITS-1:0]      idx_q, idx_d;
  logic                    out_valid_q, out_valid_d;
  logic [CH_BITS-1:0]      out_ch_q, out_ch_d;
  logic signed [WIDTH-1:0] out_q, out_d;
`ifdef IIR_LP_HIGHPASS_OUT_EN
  logic signed [WIDTH-1:0] out_hp_q, out_hp_d;
`endif

  logic                    accept;
  logic                    in_range;
  logic                    wr_en;
  logic                    clr_en;
  logic signed [ACC_W-1:0] acc_rd;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] acc_shr;
  logic signed [ACC_W-1:0] acc_next;

  assign bus.in_ready = en & (state_q == ST_IDLE);
  assign accept       = bus.in_valid & bus.in_ready;
  assign in_range     = ({1'b0, bus.in_ch} < CH_LIMIT);

  // Terms kept as separate signed signals so the shift stays arithmetic.
  assign in_ext   = signed'({{GAIN{bus.in[WIDTH-1]}}, bus.in});
  assign acc_shr  = acc_rd >>> GAIN;
  assign acc_next = acc_rd + in_ext - acc_shr;

  iir_lowpass_single_pole_mc_state_bank #(
    .CHANNELS (CHANNELS),
    .ACC_W    (ACC_W),
    .CH_BITS  (CH_BITS)
  ) u_state_bank (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (bus.in_ch),
    .rd_data (acc_rd),
    .wr_en   (wr_en),
    .wr_idx  (bus.in_ch),
    .wr_data (acc_next),
    .clr_en  (clr_en),
    .clr_idx (idx_q)
  );

  // Flush sequencing, accumulator write strobe and output register next-values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_d       = out_q;
`ifdef IIR_LP_HIGHPASS_OUT_EN
    out_hp_d    = out_hp_q;
`endif
    wr_en       = 1'b0;
    clr_en      = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            state_d = ST_FLUSH;
            idx_d   = '0;
          end
        end
        ST_FLUSH: begin
          clr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
      if (accept && in_range) begin
        wr_en       = 1'b1;
        out_valid_d = 1'b1;
        out_ch_d    = bus.in_ch;
        out_d       = acc_next[ACC_W-1 -: WIDTH];
`ifdef IIR_LP_HIGHPASS_OUT_EN
        out_hp_d    = bus.in - acc_next[ACC_W-1 -: WIDTH];
`endif
      end
    end
  end

  // FSM, flush index and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_q       <= '0;
`ifdef IIR_LP_HIGHPASS_OUT_EN
      out_hp_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_q       <= out_d;
`ifdef IIR_LP_HIGHPASS_OUT_EN
      out_hp_q    <= out_hp_d;
`endif
    end
  end

  assign busy          = (state_q == ST_FLUSH);
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out       = out_q;
`ifdef IIR_LP_HIGHPASS_OUT_EN
  assign bus.out_hp    = out_hp_q;
`endif

endmodule

// File: tb/tb_iir_lowpass_single_pole_mc.sv
// tb/tb_iir_lowpass_single_pole_mc.sv - scoreboard bench for iir_lowpass_single_pole_mc (honours IIR_LP_HIGHPASS_OUT_EN)
module tb_iir_lowpass_single_pole_mc;
  import iir_lowpass_single_pole_mc_pkg::*;

  localparam int WIDTH    = 16;
  localparam int GAIN     = 8;
  localparam int CHANNELS = 4;
  localparam int CH_BITS  = ch_bits_f(CHANNELS);
  localparam int ACC_W    = WIDTH + GAIN;

  typedef struct {
    int     ch;
    longint out;
    longint hp;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst, en, flush, busy;
  logic en3, flush3, busy3;

  int checks   = 0;
  int failures = 0;

  sb_item_t sb[$];
  sb_item_t mon_item;
  longint   model_acc   [CHANNELS];
  longint   last_out_ch [CHANNELS];
  logic     dc_phase = 1'b0;
  longint   dc_prev  = 0;
  int       mono_viol = 0;

  always #5 clk = ~clk;

  iir_lowpass_single_pole_mc_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();
  iir_lowpass_single_pole_mc_if #(.WIDTH(WIDTH), .CHANNELS(3))        bus3 ();

  iir_lowpass_single_pole_mc #(.WIDTH(WIDTH), .GAIN(GAIN), .CHANNELS(CHANNELS)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  iir_lowpass_single_pole_mc #(.WIDTH(WIDTH), .GAIN(GAIN), .CHANNELS(3)) u_dut3 (
    .clk   (clk),
    .rst   (rst),
    .en    (en3),
    .flush (flush3),
    .busy  (busy3),
    .bus   (bus3)
  );

  task automatic check_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic longint floor_div_pow2(input longint v);
    longint d;
    d = longint'(1) << GAIN;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic longint wrap_bits(input longint v, input int bits);
    longint m, r;
    m = longint'(1) << bits;
    r = v & (m - 1);
    if (r >= (m >> 1)) r = r - m;
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CHANNELS; c++) model_acc[c] = 0;
  endtask

  // Drive one sample for one cycle and record what the filter should produce for it.
  task automatic send(input int ch, input int x);
    sb_item_t it;
    longint a;
    bus.in_valid = 1'b1;
    bus.in_ch    = CH_BITS'(ch);
    bus.in       = WIDTH'(x);
    a = model_acc[ch];
    a = wrap_bits(a + x - floor_div_pow2(a), ACC_W);
    model_acc[ch] = a;
    it.ch  = ch;
    it.out = wrap_bits(floor_div_pow2(a), WIDTH);
    it.hp  = wrap_bits(x - it.out, WIDTH);
    sb.push_back(it);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    check_val(tag, sb.size(), 0);
  endtask

  // Output monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out_valid", 1, 0);
      end else begin
        mon_item = sb.pop_front();
        check_val("out_ch", bus.out_ch, mon_item.ch);
        check_val("out", bus.out, mon_item.out);
`ifdef IIR_LP_HIGHPASS_OUT_EN
        check_val("out_hp", bus.out_hp, mon_item.hp);
`endif
        last_out_ch[mon_item.ch] = bus.out;
        if (dc_phase && (bus.out_ch == 0)) begin
          if (longint'(bus.out) < dc_prev) mono_viol++;
          dc_prev = bus.out;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    en3 = 1'b1; flush3 = 1'b0;
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in = '0;
    bus3.in_valid = 1'b0; bus3.in_ch = '0; bus3.in = '0;
    model_clear();
    for (int c = 0; c < CHANNELS; c++) last_out_ch[c] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out", bus.out, 0);
    check_val("rst_out_ch", bus.out_ch, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_in_ready", bus.in_ready, 1);

    // Out-of-range tag on the 3-channel instance.
    bus3.in_valid = 1'b1; bus3.in_ch = 2'd0; bus3.in = 16'sd1000;
    @(negedge clk);
    check_val("oor_first_valid", bus3.out_valid, 1);
    check_val("oor_first_out", bus3.out, 3);
    bus3.in_ch = 2'd3; bus3.in = 16'sd5000;
    check_val("oor_in_ready", bus3.in_ready, 1);
    @(negedge clk);
    check_val("oor_no_valid", bus3.out_valid, 0);
    check_val("oor_out_hold", bus3.out, 3);
    check_val("oor_ch_hold", bus3.out_ch, 0);
    bus3.in_ch = 2'd0; bus3.in = 16'sd1000;
    @(negedge clk);
    check_val("oor_ch0_second", bus3.out, 7);
    bus3.in_ch = 2'd1; bus3.in = 16'sd256;
    @(negedge clk);
    check_val("oor_ch1_out", bus3.out, 1);
    check_val("oor_ch1_tag", bus3.out_ch, 1);
    bus3.in_valid = 1'b0;

    // DC convergence on ch0.
    dc_phase = 1'b1;
    send(0, 1000);
    #1 check_val("dc_first_out", last_out_ch[0], 3);
    for (int i = 1; i < 4000; i++) send(0, 1000);
    drain("dc_drain");
    dc_phase = 1'b0;
    check_val("dc_converged", last_out_ch[0], 1000);
    check_val("dc_monotonic_violations", mono_viol, 0);
    for (int c = 1; c < CHANNELS; c++) send(c, 0);
    drain("dc_others_drain");

    // Flush with a restart attempt in the middle of the sequence.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      check_val("flush_in_ready", bus.in_ready, 0);
      flush = (n == 1);
      n++;
      @(negedge clk);
    end
    flush = 1'b0;
    check_val("flush_busy_cycles", n, CHANNELS);
    send(0, 0);
    drain("flush_drain");
    check_val("flush_ch0_zero", last_out_ch[0], 0);

    // Flush in the same cycle as an accepted sample.
    for (int i = 0; i < 3; i++) send(2, 5000);
    flush = 1'b1;
    send(2, 5000);
    flush = 1'b0;
    model_clear();
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_val("flush_same_cycle_busy", n, CHANNELS);
    send(2, 0);
    drain("flush_same_drain");
    check_val("flush_same_ch2_zero", last_out_ch[2], 0);

    // Enable drop mid-stream; flush during the drop is ignored.
    for (int i = 0; i < 50; i++) send(3, 20000);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_ch = 2'd3; bus.in = 16'sd20000;
      flush = (i == 5);
      #1 check_val("en_low_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    flush = 1'b0;
    check_val("en_low_no_flush", busy, 0);
    en = 1'b1;
    for (int i = 0; i < 50; i++) send(3, 20000);
    drain("en_drop_drain");

    // Reset in the middle of a flush.
    send(1, 3000);
    drain("pre_rst_drain");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    check_val("mid_flush_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check_val("rst_flush_busy", busy, 0);
    check_val("rst_flush_out", bus.out, 0);
    check_val("rst_flush_out_ch", bus.out_ch, 0);
    check_val("rst_flush_valid", bus.out_valid, 0);
    for (int c = 0; c < CHANNELS; c++) send(c, 512);
    drain("rst_flush_drain");
    for (int c = 0; c < CHANNELS; c++) check_val("rst_acc_cleared", last_out_ch[c], 2);

    // Channel isolation, round-robin.
    for (int i = 0; i < 5000; i++) begin
      send(0, 16384);
      send(1, -16384);
      send(2, 0);
      send(3, 32767);
    end
    drain("iso_drain");
    check_val("iso_ch0", last_out_ch[0], 16384);
    check_val("iso_ch1", last_out_ch[1], -16384);
    check_val("iso_ch2", last_out_ch[2], 0);
    check_val("iso_ch3", last_out_ch[3], 32767);

    check_val("sb_empty_final", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
